// File: rtl/core_multicycle.sv
// Two-cycle multicycle core: FETCH presents PC to a sync-read instruction memory,
// EXEC decodes/executes; input instructions may stall in WAIT_IN until sw_valid_i.
module core_multicycle #(
    parameter int XLEN = 32,
    parameter int PC_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic [31:0]     imem_data_i,
    input  logic [XLEN-1:0] sw_data_i,
    input  logic            sw_valid_i,
    output logic            sw_ready_o,
    output logic [XLEN-1:0] hex_o,
    output logic            hex_valid_o,
    output logic            halted_o
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT_IN, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] hex_q;
    logic            hex_vld_q;

    logic [31:0]     instr;
    logic            f_b, f_c, f_we;
    logic [1:0]      f_ws;
    logic [3:0]      f_op;
    logic [4:0]      f_a1, f_a2, f_a3;
    logic signed [7:0] f_k;
    logic [XLEN-1:0] rd1, rd2, alu_res, wdata;
    logic [SHW-1:0]  shamt;
    logic            flag, is_halt, is_in, done, rf_we, hex_we;
    logic [PC_W-1:0] pc_next;

    // Memory data for the current PC arrives during EXEC, so EXEC decodes it
    // directly; ir_q holds it for the WAIT_IN cycles that follow.
    assign instr = (state_q == S_EXEC) ? imem_data_i : ir_q;
    assign {f_b, f_c, f_we, f_ws, f_op, f_a1, f_a2, f_a3} = instr[31:8];
    assign f_k   = instr[7:0];

    assign rd1   = (f_a1 == 5'd0) ? '0 : rf_q[f_a1];
    assign rd2   = (f_a2 == 5'd0) ? '0 : rf_q[f_a2];
    assign shamt = rd2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (f_op)
            4'd0:  alu_res = rd1 + rd2;
            4'd1:  alu_res = rd1 - rd2;
            4'd2:  alu_res = rd1 << shamt;
            4'd3:  alu_res = XLEN'($signed(rd1) < $signed(rd2));
            4'd4:  alu_res = XLEN'(rd1 < rd2);
            4'd5:  alu_res = rd1 ^ rd2;
            4'd6:  alu_res = rd1 >> shamt;
            4'd7:  alu_res = $signed(rd1) >>> shamt;
            4'd8:  alu_res = rd1 | rd2;
            4'd9:  alu_res = rd1 & rd2;
            4'd10: alu_res = XLEN'(rd1 == rd2);
            4'd11: alu_res = XLEN'(rd1 != rd2);
            4'd12: alu_res = XLEN'($signed(rd1) < $signed(rd2));
            4'd13: alu_res = XLEN'($signed(rd1) >= $signed(rd2));
            4'd14: alu_res = XLEN'(rd1 < rd2);
            default: alu_res = XLEN'(rd1 >= rd2);
        endcase
    end

    // Compare ops yield 0/1, so "result != 0" is the flag for every op.
    assign flag    = |alu_res;
    assign is_halt = f_b && (f_k == 8'sd0);
    assign is_in   = f_we && (f_ws == 2'b01);
    assign pc_next = (f_b || (f_c && flag)) ? pc_q + PC_W'(f_k) : pc_q + 1'b1;

    always_comb begin
        case (f_ws)
            2'b00:   wdata = XLEN'(f_k);
            2'b01:   wdata = sw_data_i;
            default: wdata = alu_res;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sw_ready_o = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_in && !sw_valid_i) begin
                    sw_ready_o = 1'b1;
                    state_d    = S_WAIT_IN;
                end else begin
                    sw_ready_o = is_in;
                    done       = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_WAIT_IN: begin
                sw_ready_o = 1'b1;
                if (sw_valid_i) begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    assign pc_d   = done ? pc_next : pc_q;
    assign rf_we  = done && f_we && (f_ws != 2'b11) && (f_a3 != 5'd0);
    assign hex_we = done && f_we && (f_ws == 2'b11);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            hex_q     <= '0;
            hex_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hex_vld_q <= hex_we;
            if (state_q == S_EXEC) ir_q  <= imem_data_i;
            if (hex_we)            hex_q <= rd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[f_a3] <= wdata;
        end
    end

    assign imem_addr_o = pc_q;
    assign hex_o       = hex_q;
    assign hex_valid_o = hex_vld_q;
    assign halted_o    = (state_q == S_HALT);
endmodule

// File: tb/tb_core_multicycle.sv
// Bench for core_multicycle: directed programs plus random programs, all checked
// against an instruction-level ISA model; a 16-bit instance covers narrow datapaths.
module tb_core_multicycle;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  imem_addr, imem_addr16;
    logic [31:0] imem_q, imem16_q;
    logic [31:0] sw_data;
    logic        sw_valid;
    logic        sw_ready, sw_ready16;
    logic [31:0] hex;
    logic [15:0] hex16;
    logic        hex_valid, hex_valid16, halted, halted16;

    core_multicycle #(.XLEN(32), .PC_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .imem_addr_o(imem_addr), .imem_data_i(imem_q),
        .sw_data_i(sw_data), .sw_valid_i(sw_valid), .sw_ready_o(sw_ready),
        .hex_o(hex), .hex_valid_o(hex_valid), .halted_o(halted));

    core_multicycle #(.XLEN(16), .PC_W(8)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .imem_addr_o(imem_addr16), .imem_data_i(imem16_q),
        .sw_data_i(sw_data[15:0]), .sw_valid_i(sw_valid), .sw_ready_o(sw_ready16),
        .hex_o(hex16), .hex_valid_o(hex_valid16), .halted_o(halted16));

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [31:0] in_vals [64];
    logic [31:0] got_q[$], exp_q[$];
    logic [15:0] last16;
    int          n_chk = 0, n_err = 0, dbl = 0, in_idx = 0;
    bit          prev_v = 0, rnd_mode = 0;
    logic [7:0]  hpc;

    localparam logic [31:0] HALT = 32'h8000_0000;

    always @(posedge clk) begin
        imem_q   <= mem[imem_addr];
        imem16_q <= mem[imem_addr16];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input bit b, c, we, input logic [1:0] ws,
                                        input logic [3:0] op, input logic [4:0] a1, a2, a3,
                                        input logic [7:0] k);
        return {b, c, we, ws, op, a1, a2, a3, k};
    endfunction
    function automatic logic [31:0] li(input logic [4:0] a3, input logic [7:0] k);
        return enc(0, 0, 1, 2'd0, 4'd0, 5'd0, 5'd0, a3, k);
    endfunction
    function automatic logic [31:0] out(input logic [4:0] a1);
        return enc(0, 0, 1, 2'd3, 4'd0, a1, 5'd0, 5'd0, 8'd0);
    endfunction
    function automatic logic [31:0] inp(input logic [4:0] a3);
        return enc(0, 0, 1, 2'd1, 4'd0, 5'd0, 5'd0, a3, 8'd0);
    endfunction
    function automatic logic [31:0] alu(input logic [3:0] op, input logic [4:0] a3, a1, a2);
        return enc(0, 0, 1, 2'd2, op, a1, a2, a3, 8'd0);
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, b);
        int signed sa, sb;
        sa = a; sb = b;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a << b[4:0];
            3: return {31'd0, sa < sb};
            4: return {31'd0, a < b};
            5: return a ^ b;
            6: return a >> b[4:0];
            7: return sa >>> b[4:0];
            8: return a | b;
            9: return a & b;
            10: return {31'd0, a == b};
            11: return {31'd0, a != b};
            12: return {31'd0, sa < sb};
            13: return {31'd0, sa >= sb};
            14: return {31'd0, a < b};
            default: return {31'd0, a >= b};
        endcase
    endfunction

    // Instruction-level reference: run mem[] from PC 0 to the halt, collecting
    // every value the program sends to hex_o.
    task automatic model_run(output logic [7:0] halt_pc);
        logic [31:0] r [32];
        logic [31:0] ins, a, bv, res, wv;
        logic [7:0]  pc;
        int          k;
        for (int i = 0; i < 32; i++) r[i] = 0;
        pc = 0; k = 0; halt_pc = 0; wv = 0;
        exp_q.delete();
        for (int s = 0; s < 4000; s++) begin
            ins = mem[pc];
            if (ins[31] && ins[7:0] == 8'd0) begin
                halt_pc = pc;
                return;
            end
            a   = r[ins[22:18]];
            bv  = r[ins[17:13]];
            res = m_alu(ins[26:23], a, bv);
            if (ins[29]) begin
                case (ins[28:27])
                    2'd0: wv = {{24{ins[7]}}, ins[7:0]};
                    2'd1: begin wv = in_vals[k]; k++; end
                    2'd2: wv = res;
                    default: exp_q.push_back(a);
                endcase
                if (ins[28:27] != 2'd3 && ins[12:8] != 5'd0) r[ins[12:8]] = wv;
            end
            if (ins[31] || (ins[30] && res != 0)) pc = pc + ins[7:0];
            else pc = pc + 8'd1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (hex_valid) begin
            got_q.push_back(hex);
            if (prev_v) dbl++;
        end
        prev_v = hex_valid;
        if (hex_valid16) last16 = hex16;
        if (rnd_mode) begin
            sw_data  = in_vals[in_idx];
            sw_valid = 1'($urandom_range(0, 1));
            if (sw_valid && sw_ready && in_idx < 63) in_idx++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        got_q.delete();
        prev_v = 0; in_idx = 0; last16 = '0;
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = HALT;
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        while (!halted && n < 3000) begin tick(); n++; end
        chk({tag, "_halted"}, halted, 1);
    endtask

    task automatic check_run(input string tag, input logic [7:0] exp_pc);
        chk({tag, "_nhex"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_hex"}, got_q[i], exp_q[i]);
        chk({tag, "_hpc"}, imem_addr, exp_pc);
    endtask

    task automatic run_prog(input string tag);
        model_run(hpc);
        do_reset();
        run_to_halt(tag);
        check_run(tag, hpc);
    endtask

    initial begin
        int rdy, bad, n;
        int unsigned kind;
        sw_valid = 0; sw_data = 0; last16 = '0;
        clear_mem();

        // reset state
        tick(); tick();
        chk("rst_pc", imem_addr, 0);
        chk("rst_hex", hex, 0);
        chk("rst_hexv", hex_valid, 0);
        chk("rst_halt", halted, 0);
        chk("rst_rdy", sw_ready, 0);

        // load-immediate sign extension and 2-cycle timing
        mem[0] = li(5, 8'hFF); mem[1] = out(5);
        model_run(hpc);
        do_reset();
        tick(); chk("t1_c1_pc", imem_addr, 0);
        tick(); chk("t1_c2_pc", imem_addr, 1);
        run_to_halt("t1");
        check_run("t1", hpc);
        chk("t1_x5", got_q.size() > 0 ? got_q[0] : 32'd0, 32'hFFFF_FFFF);

        // conditional branch taken / not taken
        for (int v = 3; v <= 4; v++) begin
            clear_mem();
            mem[0] = li(1, 8'd3); mem[1] = li(2, 8'(v));
            mem[2] = enc(1, 0, 0, 2'd0, 4'd0, 5'd0, 5'd0, 5'd0, 8'd8);
            mem[10] = enc(0, 1, 0, 2'd0, 4'd10, 5'd1, 5'd2, 5'd0, 8'hFC);
            mem[6] = out(1); mem[11] = out(2);
            run_prog("t2");
            chk("t2_pc", imem_addr, (v == 3) ? 7 : 12);
        end

        // input stall for 5 cycles
        clear_mem();
        mem[0] = inp(7); mem[1] = out(7);
        in_vals[0] = 32'h1234;
        model_run(hpc);
        do_reset();
        sw_data = 32'h1234; sw_valid = 0; rdy = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (sw_ready) rdy++;
            if (rdy == 5) chk("t3_pc_hold", imem_addr, 0);
            sw_valid = (rdy == 6);
        end
        chk("t3_rdy_cycles", rdy, 6);
        sw_valid = 0;
        run_to_halt("t3");
        check_run("t3", hpc);
        chk("t3_x7", got_q.size() > 0 ? got_q[0] : 32'd0, 32'h1234);

        // hex output and x0 hardwired
        clear_mem();
        mem[0] = li(1, 8'h55); mem[1] = li(2, 8'h50); mem[2] = alu(0, 3, 1, 2);
        mem[3] = out(3); mem[4] = li(0, 8'd9); mem[5] = out(0); mem[6] = out(3);
        run_prog("t4");
        chk("t4_a5", got_q.size() > 0 ? got_q[0] : 32'd0, 32'hA5);
        chk("t4_x0", got_q.size() > 1 ? got_q[1] : 32'd1, 32'd0);

        // halt is absorbing
        clear_mem();
        mem[0] = enc(0, 0, 0, 2'd0, 4'd0, 5'd1, 5'd1, 5'd1, 8'd5);
        run_prog("t5h");
        sw_valid = 1; bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_addr != 8'd1 || !halted || sw_ready) bad++;
        end
        chk("t5_frozen", bad, 0);
        sw_valid = 0;

        // asynchronous reset during WAIT_IN
        clear_mem();
        mem[0] = li(1, 8'h5A); mem[1] = out(1); mem[2] = inp(7); mem[3] = out(7);
        in_vals[0] = 32'h77;
        model_run(hpc);
        do_reset();
        n = 0;
        while (!sw_ready && n < 50) begin tick(); n++; end
        tick(); tick();
        chk("t5_wait_rdy", sw_ready, 1);
        chk("t5_pre_hex", hex, 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_arst_pc", imem_addr, 0);
        chk("t5_arst_hex", hex, 0);
        chk("t5_arst_rdy", sw_ready, 0);
        chk("t5_arst_halt", halted, 0);
        do_reset();
        tick();
        chk("t5_refetch", imem_addr, 0);
        sw_valid = 1; sw_data = 32'h77;
        run_to_halt("t5");
        check_run("t5", hpc);
        sw_valid = 0;

        // PC wraps 0xFF -> 0x00
        clear_mem();
        mem[0] = enc(0, 1, 0, 2'd0, 4'd11, 5'd1, 5'd0, 5'd0, 8'd2);
        mem[1] = enc(1, 0, 0, 2'd0, 4'd0, 5'd0, 5'd0, 5'd0, 8'hFD);
        mem[8'hFE] = li(1, 8'd7); mem[8'hFF] = out(1);
        run_prog("t6");
        chk("t6_wrap_hex", got_q.size() > 0 ? got_q[0] : 32'd0, 32'd7);
        chk("t6_wrap_pc", imem_addr, 2);

        // SRA on the 16-bit core
        clear_mem();
        mem[0] = li(1, 8'd1); mem[1] = li(2, 8'd15); mem[2] = alu(2, 3, 1, 2);
        mem[3] = alu(7, 4, 3, 2); mem[4] = out(4);
        run_prog("t7");
        chk("t7_sra16", last16, 16'hFFFF);

        // random straight-line programs with forward branches
        for (int it = 0; it < 8; it++) begin
            clear_mem();
            for (int i = 0; i < 64; i++) in_vals[i] = $urandom;
            for (int p = 0; p < 40; p++) begin
                kind = $urandom_range(0, 9);
                case (kind)
                    0, 1, 2: mem[p] = alu(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
                                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                    3: mem[p] = li(5'($urandom_range(0, 7)), 8'($urandom));
                    4: mem[p] = inp(5'($urandom_range(0, 7)));
                    5, 6: mem[p] = out(5'($urandom_range(0, 7)));
                    7: mem[p] = enc(0, 1, 1'($urandom_range(0, 1)), 2'd2, 4'($urandom_range(0, 15)),
                                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                    5'($urandom_range(0, 7)), 8'($urandom_range(1, 3)));
                    8: mem[p] = enc(1, 0, 1'($urandom_range(0, 1)), 2'd0, 4'd0, 5'd0, 5'd0,
                                    5'($urandom_range(0, 7)), 8'($urandom_range(1, 3)));
                    default: mem[p] = enc(0, 0, 0, 2'($urandom), 4'($urandom), 5'($urandom),
                                          5'($urandom), 5'($urandom), 8'($urandom));
                endcase
            end
            rnd_mode = 1;
            run_prog("rnd");
            rnd_mode = 0;
            sw_valid = 0;
        end

        chk("hex_pulse_single", dbl, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
